// File: rtl/reg_file16_pkg.sv
// Shared constants for the 16-entry register file and its operand-select consumers.
// Downstream mux blocks import RF_WIDTH from here so their data widths stay matched.
package reg_file16_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 16;
    localparam int ADDR_W   = 4;
    localparam int ZERO_REG = 0;

    // Address width for a given register count, never narrower than one bit.
    function automatic int addr_bits(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_file16_rf_read_port.sv
// One combinational read port: address decode, register-0 forcing and write-through bypass.
// Instantiated once per read port of reg_file16.
module rf_read_port
    import reg_file16_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    parameter int AW    = addr_bits(RF_NREGS)
) (
    input  logic             rst_i,
    input  logic [AW-1:0]    ra_i,
    input  logic [AW-1:0]    wa_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [WIDTH-1:0] regs_i [NREGS],
    output logic [WIDTH-1:0] rd_o
);

    logic ra_valid;

    // Register 0 and addresses past the last register have no storage and read as zero.
    assign ra_valid = (ra_i != AW'(ZERO_REG)) && (int'(ra_i) < NREGS);

    always_comb begin
        rd_o = '0;
        if (!rst_i && ra_valid) begin
            // ra_valid already excludes WA=0, so a matching write address is a real write.
            if (we_i && (wa_i == ra_i)) begin
                rd_o = wd_i;
            end else begin
                rd_o = regs_i[ra_i];
            end
        end
    end

endmodule

// File: rtl/reg_file16.sv
// Two-read, one-write register file with hard-wired zero register and write-through bypass.
// Storage clears asynchronously on reset; reads are combinational.
module reg_file16
    import reg_file16_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS,
    localparam int AW   = addr_bits(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic             we_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_valid;

    assign wr_valid = we_i && (wa_i != AW'(ZERO_REG)) && (int'(wa_i) < NREGS);

    always_comb begin
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[wa_i] = wd_i;
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_read_port #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rd1 (
        .rst_i  (rst_i),
        .ra_i   (ra1_i),
        .wa_i   (wa_i),
        .we_i   (we_i),
        .wd_i   (wd_i),
        .regs_i (regs_q),
        .rd_o   (rd1_o)
    );

    rf_read_port #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rd2 (
        .rst_i  (rst_i),
        .ra_i   (ra2_i),
        .wa_i   (wa_i),
        .we_i   (we_i),
        .wd_i   (wd_i),
        .regs_i (regs_q),
        .rd_o   (rd2_o)
    );

endmodule

// File: tb/tb_reg_file16.sv
// Directed, table-driven bench for reg_file16 with hand-written reset sequences.
module tb_reg_file16;

    logic        clk;
    logic        rst;
    logic [3:0]  ra1, ra2, wa;
    logic [15:0] wd;
    logic        we;
    logic [15:0] rd1, rd2;

    int checks   = 0;
    int failures = 0;

    reg_file16 dut (
        .clk_i (clk),
        .rst_i (rst),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .wa_i  (wa),
        .wd_i  (wd),
        .we_i  (we),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
        int          edges;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic w, logic [3:0] a, logic [15:0] d,
                                logic [3:0] r1, logic [3:0] r2,
                                logic [15:0] x1, logic [15:0] x2, int n);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ra1 = r1; v.ra2 = r2;
        v.e1 = x1; v.e2 = x2; v.edges = n;
        return v;
    endfunction

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        //             rst we  wa  wd       ra1 ra2  e1       e2      edges
        vecs[0]  = mk(1, 0, 0, 16'd0,     3, 7,  16'd0,    16'd0,    0);
        vecs[1]  = mk(1, 1, 1, 16'd5,     1, 1,  16'd0,    16'd0,    1);
        vecs[2]  = mk(0, 1, 1, 16'd5,     1, 0,  16'd5,    16'd0,    1);
        vecs[3]  = mk(0, 1, 2, 16'd10,    1, 2,  16'd5,    16'd10,   1);
        vecs[4]  = mk(0, 1, 3, 16'd15,    2, 3,  16'd10,   16'd15,   1);
        vecs[5]  = mk(0, 1, 4, 16'd20,    3, 4,  16'd15,   16'd20,   1);
        vecs[6]  = mk(0, 0, 0, 16'd0,     3, 4,  16'd15,   16'd20,   0);
        vecs[7]  = mk(0, 1, 0, 16'hFFFF,  0, 0,  16'd0,    16'd0,    1);
        vecs[8]  = mk(0, 0, 0, 16'hFFFF,  0, 1,  16'd0,    16'd5,    0);
        vecs[9]  = mk(0, 1, 2, 16'd99,    2, 2,  16'd99,   16'd99,   1);
        vecs[10] = mk(0, 0, 2, 16'd99,    2, 2,  16'd99,   16'd99,   0);
        vecs[11] = mk(0, 0, 1, 16'd123,   1, 4,  16'd5,    16'd20,   1);
        vecs[12] = mk(0, 0, 1, 16'd123,   1, 4,  16'd5,    16'd20,   1);
        vecs[13] = mk(0, 0, 1, 16'd123,   1, 4,  16'd5,    16'd20,   1);
        vecs[14] = mk(0, 0, 1, 16'd123,   1, 0,  16'd5,    16'd0,    0);
        vecs[15] = mk(0, 1, 6, 16'h1234,  6, 5,  16'h1234, 16'd0,    1);
        vecs[16] = mk(0, 0, 0, 16'd0,     6, 15, 16'h1234, 16'd0,    0);

        #3;
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            $display("vec %0d rst=%0b we=%0b wa=%0d wd=%h ra1=%0d ra2=%0d rd1=%h rd2=%h",
                     i, rst, we, wa, wd, ra1, ra2, rd1, rd2);
            for (int e = 0; e < vecs[i].edges; e++) tick();
        end

        // Reset arriving between edges while a write to r5 is pending.
        we = 1'b1; wa = 4'd5; wd = 16'd7; ra1 = 4'd5; ra2 = 4'd4;
        tick();
        we = 1'b0; #1;
        check("r5_written", rd1, 16'd7);
        we = 1'b1; wa = 4'd5; wd = 16'd8; #1;
        check("r5_bypass_pre_rst", rd1, 16'd8);
        rst = 1'b1; #1;
        check("rst_async_rd1", rd1, 16'd0);
        check("rst_async_rd2", rd2, 16'd0);
        tick();
        check("rst_wins_edge", rd1, 16'd0);
        rst = 1'b0; we = 1'b0; ra2 = 4'd1; #1;
        check("post_rst_r5", rd1, 16'd0);
        check("post_rst_r1", rd2, 16'd0);
        tick();
        check("post_rst_r5_edge", rd1, 16'd0);
        $display("seq reset-mid-write done rd1=%h rd2=%h", rd1, rd2);

        // First write after reset lands on the first clean edge.
        we = 1'b1; wa = 4'd5; wd = 16'd8; ra2 = 4'd6;
        tick();
        we = 1'b0; #1;
        check("first_write_r5", rd1, 16'd8);
        check("r6_cleared", rd2, 16'd0);
        $display("seq first-write rd1=%h rd2=%h", rd1, rd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file16.md
REG_FILE16 -- requirements
Module: reg_file16

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register and data port; SHALL be the only width constant used for data.
REQ-002 Parameter NREGS, default 16, register count; address width SHALL be log2(NREGS) (4 at default).
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 RA1  input  4  read address, port 1.
REQ-006 RA2  input  4  read address, port 2.
REQ-007 WA  input  4  write address.
REQ-008 WD  input  WIDTH  write data.
REQ-009 WE  input  1  write enable, sampled at CLK rising edge.
REQ-010 RD1  output  WIDTH  read data, port 1; feeds the operand-select mux inputs downstream.
REQ-011 RD2  output  WIDTH  read data, port 2; feeds the operand-select mux inputs downstream.

Function
REQ-012 Storage SHALL be NREGS registers of WIDTH bits; register 0 SHALL read as 0 at all times and SHALL ignore writes.
REQ-013 Write: at CLK rising edge with WE=1 and WA!=0, register[WA] SHALL take WD; WE=0 SHALL leave all registers unchanged.
REQ-014 Reads SHALL be combinational: RDn = register[RAn] with zero added clock latency.
REQ-015 Write-through bypass: when WE=1, WA!=0 and RAn==WA, RDn SHALL present WD in the same cycle, before the edge.
REQ-016 Bypass SHALL never apply for WA=0; RAn=0 SHALL give 0 even when WE=1, WA=0, WD!=0.
REQ-017 RA1==RA2 SHALL return identical data on both ports, including the bypass case.
REQ-018 Address wrap: no out-of-range address exists at default NREGS; when NREGS is not a power of two, addresses >= NREGS SHALL read 0 and SHALL not be written.
REQ-019 Outputs SHALL never be X after reset is deasserted, for any address combination.

Reset
REQ-020 RST=1 SHALL clear every register to 0 immediately, without waiting for CLK; RD1 and RD2 SHALL read 0 while RST=1.
REQ-021 RST asserted mid-write, in the same cycle as WE=1, SHALL win: the register SHALL hold 0 after the edge.
REQ-022 While RST=1, the bypass SHALL be suppressed.
REQ-023 The first write SHALL be the first CLK rising edge with RST=0 and WE=1.

Structure
REQ-024 A shared package SHALL hold WIDTH default 16, NREGS default 16, ADDR_W 4, ZERO_REG 0; the downstream mux blocks SHALL import the same WIDTH.
REQ-025 One sub-module, rf_read_port, SHALL implement address decode, zero-register forcing and bypass; it SHALL be instantiated twice.
REQ-026 The storage array and write logic SHALL live in reg_file16 itself, with no latches inferred.

Verification
REQ-027 Reset: RST=1 with no CLK, then any RA1/RA2 -> RD1=RD2=0.
REQ-028 Write/read: write 5,10,15,20 to r1..r4 on successive edges; then RA1=3, RA2=4 -> RD1=15, RD2=20.
REQ-029 Zero register: WE=1, WA=0, WD=16'hFFFF, edge; then RA1=0 -> RD1=0 both before and after the edge.
REQ-030 Bypass: r2=10; WE=1, WA=2, WD=99, RA1=RA2=2 before the edge -> RD1=RD2=99; after the edge with WE=0 -> 99.
REQ-031 Reset mid-operation: r5=7; assert RST with WE=1, WA=5, WD=8 between edges -> RD1 (RA1=5) drops to 0 immediately and stays 0 after RST deasserts.
REQ-032 Hold: WE=0, WA=1, WD=123 over 3 edges -> r1 keeps 5.
